fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the single-cycle cpu's decode/execute datapath.
- Holds the PC and drives the word address into the instruction memory, which is loaded from memory.dat and read combinationally.
- Registers the returned instruction, with its PC, into a one-entry output slot under a valid/ready handshake.
- Applies branch, jump and jr redirects from downstream, and counts retired fetches for bench visibility.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding a single-cycle cpu.
//
// Holds the fetch PC, presents the word address to a combinational
// instruction memory and captures the returned word (with its PC) in a
// one-entry output slot under a valid/ready handshake. Branch, jump and
// jr redirects from downstream are applied when the slot is accepted.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   imem_addr / imem_data  word address out, instruction word in (same cycle)
//   instr, instr_pc        registered instruction and its PC
//   instr_valid            slot holds a live instruction
//   instr_ready            downstream accepts the slot this cycle
//   halt                   stop issuing new fetches; slot still drains
//   branch_taken/offset    PC-relative redirect (signed word offset)
//   jump/jump_target       J-type redirect within the current 256 MB region
//   jr/jr_addr             register-indirect redirect
//   pc                     current fetch PC
//   misalign_fault         sticky: a jr target had nonzero low bits
//   fetch_count            number of accepted instructions (wraps)
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 10
) (
   input  logic               clk,
   input  logic               reset,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_data,
   output logic [31:0]        instr,
   output logic [31:0]        instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               halt,
   input  logic               branch_taken,
   input  logic [15:0]        branch_offset,
   input  logic               jump,
   input  logic [25:0]        jump_target,
   input  logic               jr,
   input  logic [31:0]        jr_addr,
   output logic [31:0]        pc,
   output logic               misalign_fault,
   output logic [31:0]        fetch_count
);

   logic        accept;
   logic        slot_free;
   logic        redirect;
   logic [31:0] seq_pc;
   logic [31:0] br_disp;
   logic [31:0] target;

   // The PC is byte-addressed; memory depth wrap falls out of the slice.
   assign imem_addr = pc[IMEM_AW+1:2];

   assign accept    = instr_valid & instr_ready;
   assign slot_free = !instr_valid | instr_ready;
   assign redirect  = branch_taken | jump | jr;

   // Targets are relative to the instruction being retired, not to pc.
   assign seq_pc  = instr_pc + 32'd4;
   assign br_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

   always_comb begin
      target = seq_pc + br_disp;
      if (jr)
         target = jr_addr;
      else if (jump)
         target = {seq_pc[31:28], jump_target, 2'b00};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc             <= RESET_PC;
         instr          <= 32'd0;
         instr_pc       <= 32'd0;
         instr_valid    <= 1'b0;
         misalign_fault <= 1'b0;
         fetch_count    <= 32'd0;
      end else begin
         if (accept)
            fetch_count <= fetch_count + 32'd1;

         if (accept && redirect) begin
            // The word fetched this cycle is wrong-path: drop it, leaving
            // a single bubble before the target word arrives.
            pc          <= target & ~32'd3;
            instr_valid <= 1'b0;
            if (jr && (jr_addr[1:0] != 2'b00))
               misalign_fault <= 1'b1;
         end else if (slot_free && !halt) begin
            instr       <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
         end else if (slot_free) begin
            // Halted: let the slot drain, hold pc.
            instr_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Directed sequences, a table of redirect vectors, and a randomized run
// scored against an architectural instruction-stream model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          IMEM_AW  = 10;

   logic               clk = 1'b0;
   logic               reset;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_data;
   logic [31:0]        instr, instr_pc;
   logic               instr_valid;
   logic               instr_ready;
   logic               halt;
   logic               branch_taken;
   logic [15:0]        branch_offset;
   logic               jump;
   logic [25:0]        jump_target;
   logic               jr;
   logic [31:0]        jr_addr;
   logic [31:0]        pc;
   logic               misalign_fault;
   logic [31:0]        fetch_count;

   logic [31:0] mem [0:(1<<IMEM_AW)-1];
   assign imem_data = mem[imem_addr];

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW)) dut (
      .clk(clk), .reset(reset),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .halt(halt),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target),
      .jr(jr), .jr_addr(jr_addr),
      .pc(pc), .misalign_fault(misalign_fault), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] at_pc;
      logic        br;
      logic        jmp;
      logic        jrr;
      logic [15:0] off;
      logic [25:0] jt;
      logic [31:0] ja;
      logic [31:0] exp_pc;
      logic        exp_mis;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Inputs change at negedge; one call advances across one active edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_redirects();
      branch_taken = 1'b0; branch_offset = 16'd0;
      jump = 1'b0; jump_target = 26'd0;
      jr = 1'b0; jr_addr = 32'd0;
   endtask

   task automatic do_reset();
      reset = 1'b1; halt = 1'b0; instr_ready = 1'b1;
      clear_redirects();
      tick();
      reset = 1'b0;
   endtask

   // Bring the slot to a live instruction at addr via an accepted jr.
   task automatic steer(input logic [31:0] addr);
      int n = 0;
      while (!instr_valid && n < 10) begin
         tick();
         n++;
      end
      chk("steer_wait_valid", {31'd0, instr_valid}, 32'd1);
      instr_ready = 1'b1; jr = 1'b1; jr_addr = addr;
      tick();
      clear_redirects();
      tick();
      chk("steer_instr_pc", instr_pc, addr);
   endtask

   logic [31:0] exp_next, tgt, p_target, p_ipc, p_instr, p_pc;
   logic        mis, acc, p_first, p_acc, p_redir, p_valid, p_ready, p_halt;
   int          cnt, naccept;

   initial begin
      vecs[0] = '{32'h08,       1, 0, 0, 16'h0003, 26'h0,  32'h0, 32'h18,       0};
      vecs[1] = '{32'h08,       1, 0, 0, 16'hFFFE, 26'h0,  32'h0, 32'h04,       0};
      vecs[2] = '{32'h10,       1, 0, 0, 16'hFFFF, 26'h0,  32'h0, 32'h10,       0};
      vecs[3] = '{32'h00,       1, 1, 1, 16'h0005, 26'h10, 32'h40, 32'h40,      0};
      vecs[4] = '{32'h00,       0, 1, 0, 16'h0000, 26'h10, 32'h0, 32'h40,       0};
      vecs[5] = '{32'h00,       1, 1, 0, 16'h0001, 26'h20, 32'h0, 32'h80,       0};
      vecs[6] = '{32'hF000_0000, 0, 1, 0, 16'h0000, 26'h1, 32'h0, 32'hF000_0004, 0};
      vecs[7] = '{32'hFFFF_FFFC, 1, 0, 0, 16'h0001, 26'h0, 32'h0, 32'h0000_0004, 0};
      vecs[8] = '{32'h00,       0, 0, 1, 16'h0000, 26'h0,  32'h43, 32'h40,      1};

      for (int i = 0; i < (1<<IMEM_AW); i++) mem[i] = 32'h2008_0001 + i;

      // Reset state
      reset = 1'b1; halt = 1'b0; instr_ready = 1'b1;
      clear_redirects();
      tick(); tick();
      chk("rst_pc", pc, RESET_PC);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_misalign", {31'd0, misalign_fault}, 32'd0);
      chk("rst_count", fetch_count, 32'd0);

      // Sequential fetch
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("seq_valid", {31'd0, instr_valid}, 32'd1);
         chk("seq_instr", instr, 32'h2008_0001 + k);
         chk("seq_instr_pc", instr_pc, 32'(4*k));
      end
      tick();
      chk("seq_count", fetch_count, 32'd4);

      // Backpressure
      do_reset();
      tick(); tick();
      instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_instr_pc", instr_pc, 32'h4);
         chk("bp_instr", instr, 32'h2008_0002);
         chk("bp_pc", pc, 32'h8);
         chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      end
      instr_ready = 1'b1;
      tick();
      chk("bp_release_pc", instr_pc, 32'h8);
      chk("bp_release_instr", instr, 32'h2008_0003);
      chk("bp_count", fetch_count, 32'd2);

      // Redirect table
      for (int i = 0; i < 9; i++) begin
         do_reset();
         steer(vecs[i].at_pc);
         branch_taken = vecs[i].br; branch_offset = vecs[i].off;
         jump = vecs[i].jmp; jump_target = vecs[i].jt;
         jr = vecs[i].jrr; jr_addr = vecs[i].ja;
         tick();
         clear_redirects();
         chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d_bubble", i), {31'd0, instr_valid}, 32'd0);
         chk($sformatf("vec%0d_misalign", i), {31'd0, misalign_fault}, {31'd0, vecs[i].exp_mis});
         tick();
         chk($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, 32'd1);
         chk($sformatf("vec%0d_instr", i), instr, mem[vecs[i].exp_pc[IMEM_AW+1:2]]);
      end

      // Misalign stays sticky until reset
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mis_sticky", {31'd0, misalign_fault}, 32'd1);
      end
      do_reset();
      chk("mis_cleared", {31'd0, misalign_fault}, 32'd0);

      // Halt drains the slot and holds pc
      tick();
      halt = 1'b1;
      tick();
      chk("halt_drain", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc", pc, 32'h4);
      tick();
      chk("halt_hold_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_hold_pc", pc, 32'h4);
      halt = 1'b0;
      tick();
      chk("unhalt_instr_pc", instr_pc, 32'h4);

      // Reset wins over a simultaneous jr
      reset = 1'b1; jr = 1'b1; jr_addr = 32'h40;
      tick();
      clear_redirects();
      chk("rstjr_pc", pc, RESET_PC);
      chk("rstjr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rstjr_instr", instr, 32'd0);
      chk("rstjr_instr_pc", instr_pc, 32'd0);
      chk("rstjr_count", fetch_count, 32'd0);
      reset = 1'b0;

      // Memory address wrap
      tick();
      jr = 1'b1; jr_addr = 32'hFFC;
      tick();
      clear_redirects();
      chk("wrap_addr_top", {22'd0, imem_addr}, 32'd1023);
      tick();
      chk("wrap_instr_top", instr, mem[1023]);
      chk("wrap_addr_zero", {22'd0, imem_addr}, 32'd0);
      chk("wrap_pc", pc, 32'h1000);
      tick();
      chk("wrap_instr_zero", instr, mem[0]);
      chk("wrap_instr_pc", instr_pc, 32'h1000);

      // Randomized run against the instruction-stream model
      for (int i = 0; i < (1<<IMEM_AW); i++) mem[i] = $urandom;
      do_reset();
      exp_next = RESET_PC; cnt = 0; mis = 1'b0; naccept = 0; p_first = 1'b1;
      p_acc = 0; p_redir = 0; p_valid = 0; p_ready = 0; p_halt = 0;
      p_target = 0; p_ipc = 0; p_instr = 0; p_pc = 0;
      for (int c = 0; c < 2500; c++) begin
         if (!p_first) begin
            chk("rnd_count", fetch_count, 32'(cnt));
            chk("rnd_misalign", {31'd0, misalign_fault}, {31'd0, mis});
            chk("rnd_imem_addr", {22'd0, imem_addr}, (pc / 4) % (1 << IMEM_AW));
            if (p_acc && p_redir) begin
               chk("rnd_bubble", {31'd0, instr_valid}, 32'd0);
               chk("rnd_redirect_pc", pc, p_target);
            end else if (p_valid && !p_ready) begin
               chk("rnd_stall_valid", {31'd0, instr_valid}, 32'd1);
               chk("rnd_stall_pc", instr_pc, p_ipc);
               chk("rnd_stall_instr", instr, p_instr);
               chk("rnd_stall_fpc", pc, p_pc);
            end else if (!p_halt) begin
               chk("rnd_fetch_valid", {31'd0, instr_valid}, 32'd1);
               chk("rnd_fetch_ipc", instr_pc, p_pc);
               chk("rnd_fetch_pc", pc, p_pc + 32'd4);
            end else begin
               chk("rnd_halt_valid", {31'd0, instr_valid}, 32'd0);
               chk("rnd_halt_pc", pc, p_pc);
            end
         end
         p_first = 1'b0;

         instr_ready   = ($urandom_range(0, 3) != 0);
         halt          = ($urandom_range(0, 7) == 0);
         branch_taken  = ($urandom_range(0, 7) == 0);
         branch_offset = 16'($urandom);
         jump          = ($urandom_range(0, 15) == 0);
         jump_target   = 26'($urandom);
         jr            = ($urandom_range(0, 15) == 0);
         jr_addr       = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'd3);

         acc = instr_valid && instr_ready;
         if (acc) begin
            naccept++;
            chk("rnd_stream_pc", instr_pc, exp_next);
            chk("rnd_stream_instr", instr, mem[exp_next[IMEM_AW+1:2]]);
            cnt++;
            if (jr) begin
               tgt = jr_addr;
               if (jr_addr % 4 != 0) mis = 1'b1;
            end else if (jump) begin
               tgt = ((exp_next + 32'd4) & 32'hF000_0000) | (32'(jump_target) * 4);
            end else if (branch_taken) begin
               tgt = exp_next + 32'd4 + 32'(4 * int'($signed(branch_offset)));
            end else begin
               tgt = exp_next + 32'd4;
            end
            exp_next = tgt & 32'hFFFF_FFFC;
         end
         p_acc = acc; p_redir = branch_taken | jump | jr; p_target = exp_next;
         p_valid = instr_valid; p_ready = instr_ready; p_halt = halt;
         p_ipc = instr_pc; p_instr = instr; p_pc = pc;
         tick();
      end
      chk("rnd_enough_accepts", {31'd0, naccept > 500}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
